// File: rtl/student_fir_sample_ctrl.sv
// ---------------------------------------------------------------------------
// student_fir_sample_ctrl
//
// Sample delay-line controller for a FIR filter. Each accepted sample is
// written into a dual-port RAM that acts as a circular delay line. The last
// NumTaps samples are then read back newest-first and streamed to a MAC stage.
// The whole delay line is zeroed after reset and on clear_i requests.
//
// Ports
//   clk_i, rst_ni                      clock (rising edge), async active-low reset
//   sample_i/sample_valid_i/sample_ready_o
//                                      upstream sample handshake
//   clear_i                            request to zero the whole delay line
//   ena_o, wea_o, addra_o, dia_o       DPRAM write port
//   enb_o, addrb_o, dob_i              DPRAM read port (1-cycle read latency)
//   tap_sample_o, tap_idx_o, tap_valid_o, tap_last_o
//                                      tap stream to the MAC stage
//   busy_o                             high whenever the controller is not idle
// ---------------------------------------------------------------------------
module student_fir_sample_ctrl #(
  parameter int AddrWidth = 10,
  parameter int DataSize  = 16,
  parameter int NumTaps   = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DataSize-1:0]  sample_i,
  input  logic                 sample_valid_i,
  output logic                 sample_ready_o,
  input  logic                 clear_i,
  output logic                 ena_o,
  output logic                 wea_o,
  output logic [AddrWidth-1:0] addra_o,
  output logic [DataSize-1:0]  dia_o,
  output logic                 enb_o,
  output logic [AddrWidth-1:0] addrb_o,
  input  logic [DataSize-1:0]  dob_i,
  output logic [DataSize-1:0]  tap_sample_o,
  output logic [AddrWidth-1:0] tap_idx_o,
  output logic                 tap_valid_o,
  output logic                 tap_last_o,
  output logic                 busy_o
);

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StWrite,
    StRead,
    StDrain
  } state_e;

  localparam logic [AddrWidth-1:0] LastAddr = '1;
  localparam logic [AddrWidth-1:0] LastTap  = AddrWidth'(NumTaps - 1);

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] clr_cnt_q;
  logic [AddrWidth-1:0] wr_ptr_q;
  logic [AddrWidth-1:0] k_q;
  logic [AddrWidth-1:0] tap_idx_q;
  logic [DataSize-1:0]  sample_q;
  logic                 tap_valid_q;
  logic                 accept;

  // A sample is taken only in IDLE, and a simultaneous clear request wins.
  assign accept = (state_q == StIdle) && sample_valid_i && !clear_i;

  // State register. Reset lands in CLEAR so the delay line is always zeroed
  // before the first sample is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StClear;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. WRITE and DRAIN are single-cycle states; READ lasts
  // exactly NumTaps cycles, one RAM read issued per cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClear: if (clr_cnt_q == LastAddr) state_d = StIdle;
      StIdle: begin
        if (clear_i) begin
          state_d = StClear;
        end else if (sample_valid_i) begin
          state_d = StWrite;
        end
      end
      StWrite: state_d = StRead;
      StRead:  if (k_q == LastTap) state_d = StDrain;
      StDrain: state_d = StIdle;
      default: state_d = StClear;
    endcase
  end

  // Datapath registers: clear counter, circular write pointer, tap counter,
  // captured sample and the one-cycle tap pipeline that lines up with the
  // RAM read latency. The write pointer only advances after the whole tap
  // stream has been issued, so every read of a sample sees the same base.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clr_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      k_q         <= '0;
      sample_q    <= '0;
      tap_valid_q <= 1'b0;
      tap_idx_q   <= '0;
    end else begin
      tap_valid_q <= (state_q == StRead);
      tap_idx_q   <= k_q;
      unique case (state_q)
        StClear: begin
          if (clr_cnt_q == LastAddr) begin
            clr_cnt_q <= '0;
            wr_ptr_q  <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        StIdle: begin
          if (accept) sample_q <= sample_i;
        end
        StWrite: k_q <= '0;
        StRead: begin
          if (k_q == LastTap) begin
            k_q <= '0;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StDrain: wr_ptr_q <= wr_ptr_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Output decode. Everything is forced low while reset is held, so the RAM
  // sees no write strobe even though the state register already says CLEAR.
  // The read address walks backwards from the write pointer, which makes
  // tap 0 the newest sample; the subtraction wraps naturally.
  always_comb begin
    sample_ready_o = 1'b0;
    ena_o          = 1'b0;
    wea_o          = 1'b0;
    addra_o        = '0;
    dia_o          = '0;
    enb_o          = 1'b0;
    addrb_o        = '0;
    busy_o         = 1'b0;
    tap_sample_o   = '0;
    tap_idx_o      = '0;
    tap_valid_o    = 1'b0;
    tap_last_o     = 1'b0;
    if (rst_ni) begin
      busy_o       = (state_q != StIdle);
      tap_sample_o = dob_i;
      tap_idx_o    = tap_idx_q;
      tap_valid_o  = tap_valid_q;
      tap_last_o   = tap_valid_q && (tap_idx_q == LastTap);
      unique case (state_q)
        StClear: begin
          ena_o   = 1'b1;
          wea_o   = 1'b1;
          addra_o = clr_cnt_q;
        end
        StIdle: sample_ready_o = !clear_i;
        StWrite: begin
          ena_o   = 1'b1;
          wea_o   = 1'b1;
          addra_o = wr_ptr_q;
          dia_o   = sample_q;
        end
        StRead: begin
          enb_o   = 1'b1;
          addrb_o = wr_ptr_q - k_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_student_fir_sample_ctrl.sv
// ---------------------------------------------------------------------------
// tb_student_fir_sample_ctrl
//
// Drives student_fir_sample_ctrl (AddrWidth=4, NumTaps=4) with an attached
// DPRAM model. A behavioural reference keeps the list of samples accepted
// since the last clear and the per-sample timeline, and every cycle the
// DUT outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_student_fir_sample_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int NT    = 4;
  localparam int Depth = 1 << AW;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic [DW-1:0] sample_i = '0;
  logic          sample_valid_i = 1'b0;
  logic          sample_ready_o;
  logic          clear_i = 1'b0;
  logic          ena_o, wea_o, enb_o;
  logic [AW-1:0] addra_o, addrb_o;
  logic [DW-1:0] dia_o, dob_i;
  logic [DW-1:0] tap_sample_o;
  logic [AW-1:0] tap_idx_o;
  logic          tap_valid_o, tap_last_o, busy_o;

  int checks = 0;
  int fails  = 0;

  student_fir_sample_ctrl #(.AddrWidth(AW), .DataSize(DW), .NumTaps(NT)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .clear_i        (clear_i),
    .ena_o          (ena_o),
    .wea_o          (wea_o),
    .addra_o        (addra_o),
    .dia_o          (dia_o),
    .enb_o          (enb_o),
    .addrb_o        (addrb_o),
    .dob_i          (dob_i),
    .tap_sample_o   (tap_sample_o),
    .tap_idx_o      (tap_idx_o),
    .tap_valid_o    (tap_valid_o),
    .tap_last_o     (tap_last_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // DPRAM model, seeded with garbage so a missing clear write shows up.
  logic [DW-1:0] mem [Depth];
  initial begin
    for (int i = 0; i < Depth; i++) mem[i] = DW'($urandom);
    dob_i = '0;
  end
  always @(posedge clk_i) begin
    if (ena_o && wea_o) mem[addra_o] <= dia_o;
    if (enb_o) dob_i <= mem[addrb_o];
  end

  // Reference model: clearing for Depth cycles, idle, or busy with a sample
  // at a given offset from its acceptance cycle.
  typedef enum {MClear, MIdle, MBusy} mode_e;
  mode_e         mMode = MClear;
  int            mOff  = 0;
  int            mWp   = 0;
  logic [DW-1:0] hist[$];

  function automatic logic [DW-1:0] expTap(int k);
    if (k < hist.size()) return hist[hist.size() - 1 - k];
    return '0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic startClear();
    mMode = MClear;
    mOff  = 0;
    mWp   = 0;
    hist.delete();
  endtask

  // One clock cycle: drive inputs at the falling edge, compare outputs to the
  // model shortly after, then advance the model as of the next rising edge.
  task automatic applyStimulus(input logic v, input logic c, input logic [DW-1:0] d,
                               output logic accepted);
    logic          eBusy, eReady, eEna, eEnb, eTv, eLast;
    logic [AW-1:0] eAddra, eAddrb, eIdx;
    logic [DW-1:0] eDia, eTs;
    accepted = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    sample_valid_i = v;
    clear_i = c;
    sample_i = d;
    #1;
    eBusy = 1'b1; eReady = 1'b0; eEna = 1'b0; eEnb = 1'b0; eTv = 1'b0; eLast = 1'b0;
    eAddra = '0; eAddrb = '0; eIdx = '0; eDia = '0; eTs = '0;
    case (mMode)
      MClear: begin
        eEna = 1'b1;
        eAddra = AW'(mOff);
      end
      MIdle: begin
        eBusy = 1'b0;
        eReady = !c;
      end
      default: begin
        if (mOff == 1) begin
          eEna = 1'b1;
          eAddra = AW'(mWp);
          eDia = hist[hist.size() - 1];
        end
        if (mOff >= 2 && mOff <= NT + 1) begin
          eEnb = 1'b1;
          eAddrb = AW'((mWp - (mOff - 2)) & (Depth - 1));
        end
        if (mOff >= 3) begin
          eTv = 1'b1;
          eIdx = AW'(mOff - 3);
          eLast = (mOff - 3 == NT - 1);
          eTs = expTap(mOff - 3);
        end
      end
    endcase
    checkOutput("busy", 32'(busy_o), 32'(eBusy));
    checkOutput("ready", 32'(sample_ready_o), 32'(eReady));
    checkOutput("ena", 32'(ena_o), 32'(eEna));
    checkOutput("wea", 32'(wea_o), 32'(eEna));
    checkOutput("enb", 32'(enb_o), 32'(eEnb));
    checkOutput("tap_valid", 32'(tap_valid_o), 32'(eTv));
    checkOutput("tap_last", 32'(tap_last_o), 32'(eLast));
    if (eEna) begin
      checkOutput("addra", 32'(addra_o), 32'(eAddra));
      checkOutput("dia", 32'(dia_o), 32'(eDia));
    end
    if (eEnb) checkOutput("addrb", 32'(addrb_o), 32'(eAddrb));
    if (eTv) begin
      checkOutput("tap_idx", 32'(tap_idx_o), 32'(eIdx));
      checkOutput("tap_sample", 32'(tap_sample_o), 32'(eTs));
    end
    case (mMode)
      MClear: begin
        if (mOff == Depth - 1) mMode = MIdle;
        else mOff++;
      end
      MIdle: begin
        if (c) begin
          startClear();
        end else if (v) begin
          hist.push_back(d);
          if (hist.size() > Depth) void'(hist.pop_front());
          mMode = MBusy;
          mOff = 1;
          accepted = 1'b1;
        end
      end
      default: begin
        if (mOff == NT + 2) begin
          mMode = MIdle;
          mWp = (mWp + 1) % Depth;
        end else begin
          mOff++;
        end
      end
    endcase
  endtask

  // Asserts reset mid-cycle, checks that all outputs collapse at once, holds
  // it through one rising edge and leaves the model at the start of CLEAR.
  task automatic doReset();
    rst_ni = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput("rst_busy", 32'(busy_o), 32'd0);
      checkOutput("rst_ready", 32'(sample_ready_o), 32'd0);
      checkOutput("rst_ena", 32'(ena_o), 32'd0);
      checkOutput("rst_wea", 32'(wea_o), 32'd0);
      checkOutput("rst_enb", 32'(enb_o), 32'd0);
      checkOutput("rst_tap_valid", 32'(tap_valid_o), 32'd0);
      checkOutput("rst_tap_last", 32'(tap_last_o), 32'd0);
      checkOutput("rst_addra", 32'(addra_o), 32'd0);
      checkOutput("rst_addrb", 32'(addrb_o), 32'd0);
      checkOutput("rst_dia", 32'(dia_o), 32'd0);
      if (i == 0) @(negedge clk_i);
    end
    startClear();
  endtask

  task automatic idleFor(input int n);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, acc);
  endtask

  task automatic waitIdle();
    logic acc;
    int   cyc = 0;
    while (mMode != MIdle && cyc < 100) begin
      applyStimulus(1'b0, 1'b0, '0, acc);
      cyc++;
    end
    checkOutput("idle_budget", 32'(cyc < 100), 32'd1);
  endtask

  // Feeds consecutive values first..first+count-1. Without gaps valid stays
  // high, so acceptances must be exactly NumTaps+3 cycles apart.
  task automatic feedSamples(input int first, input int count, input bit gaps);
    logic acc;
    int   cur = first;
    int   got = 0;
    int   cyc = 0;
    int   lastAcc = -1;
    int   budget = count * (NT + 3) * 4 + 40;
    while (got < count && cyc < budget) begin
      applyStimulus(gaps ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, DW'(cur), acc);
      if (acc) begin
        if (!gaps && lastAcc >= 0) checkOutput("accept_gap", 32'(cyc - lastAcc), 32'(NT + 3));
        lastAcc = cyc;
        cur++;
        got++;
      end
      cyc++;
    end
    checkOutput("feed_count", 32'(got), 32'(count));
  endtask

  task automatic randomRun(input int n);
    logic acc;
    for (int i = 0; i < n; i++)
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0),
                    DW'($urandom), acc);
  endtask

  initial begin
    logic acc;
    #2;
    doReset();
    // Power-up clear, then the first three samples.
    idleFor(Depth + 2);
    feedSamples(1, 3, 1'b0);
    waitIdle();
    // Twenty back-to-back samples wrap the write pointer.
    feedSamples(1, 20, 1'b0);
    waitIdle();
    // Clear and valid together: clear wins, nothing accepted.
    applyStimulus(1'b1, 1'b1, 16'hAAAA, acc);
    checkOutput("clear_no_accept", 32'(acc), 32'd0);
    feedSamples(16'h0100, 1, 1'b0);
    waitIdle();
    feedSamples(16'h0200, 6, 1'b1);
    randomRun(400);
    waitIdle();
    // Reset in the middle of the tap stream, at read index 2.
    feedSamples(16'h0300, 1, 1'b0);
    idleFor(4);
    checkOutput("pre_reset_tap_valid", 32'(tap_valid_o), 32'd1);
    doReset();
    idleFor(Depth + 2);
    feedSamples(16'h0400, 2, 1'b0);
    randomRun(300);
    waitIdle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/student_fir_sample_ctrl.md
STUDENT_FIR_SAMPLE_CTRL -- requirements
Module: student_fir_sample_ctrl

Interface
REQ-001 SHALL have parameter AddrWidth, default 10: sample delay-line address width.
REQ-002 SHALL have parameter DataSize, default 16: sample width.
REQ-003 SHALL have parameter NumTaps, default 1024: taps read per sample; legal range 1..2**AddrWidth.
REQ-004 SHALL have port clk_i  input  1: single clock, rising edge.
REQ-005 SHALL have port rst_ni  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have ports sample_i  input  DataSize, sample_valid_i  input  1, sample_ready_o  output  1: upstream sample handshake.
REQ-007 SHALL have port clear_i  input  1: request to zero the whole delay line.
REQ-008 SHALL have ports ena_o, wea_o  output  1; addra_o  output  AddrWidth; dia_o  output  DataSize: sample DPRAM write port.
REQ-009 SHALL have ports enb_o  output  1; addrb_o  output  AddrWidth; dob_i  input  DataSize: sample DPRAM read port, 1-cycle read latency.
REQ-010 SHALL have ports tap_sample_o  output  DataSize, tap_idx_o  output  AddrWidth, tap_valid_o  output  1, tap_last_o  output  1: stream to MAC stage.
REQ-011 SHALL have port busy_o  output  1: high whenever state is not IDLE.

Function
REQ-012 SHALL implement states CLEAR, IDLE, WRITE, READ, DRAIN.
REQ-013 CLEAR: each cycle drive ena_o=wea_o=1, dia_o=0, addra_o=clr_cnt; clr_cnt increments; after address 2**AddrWidth-1 go IDLE, clr_cnt and wr_ptr reset to 0.
REQ-014 IDLE: sample_ready_o = !clear_i; RAM enables 0; clear_i=1 -> CLEAR (clear has priority, no sample accepted that cycle).
REQ-015 IDLE with sample_valid_i=1 and clear_i=0: sample captured, next state WRITE.
REQ-016 WRITE (one cycle): ena_o=wea_o=1, addra_o=wr_ptr, dia_o=captured sample; next READ with k=0.
REQ-017 READ: enb_o=1, addrb_o=(wr_ptr-k) mod 2**AddrWidth, k increments per cycle; after k=NumTaps-1 issued go DRAIN.
REQ-018 tap_valid_o SHALL equal enb_o delayed one cycle; tap_sample_o=dob_i combinationally; tap_idx_o=k delayed one cycle; tap_last_o=tap_valid_o and tap_idx_o=NumTaps-1.
REQ-019 DRAIN (one cycle): emits final tap; wr_ptr increments mod 2**AddrWidth; next IDLE.
REQ-020 Per-sample latency: accept at cycle t -> write t+1 -> tap 0 valid t+3 -> tap_last t+2+NumTaps -> sample_ready_o high again t+3+NumTaps.
REQ-021 Write and read ports SHALL never be enabled in the same cycle; wea_o never high without ena_o.
REQ-022 tap 0 SHALL be the newest sample; tap k the sample accepted k samples earlier; positions never written since last clear read 0.
REQ-023 Address arithmetic wraps modulo 2**AddrWidth without error.
REQ-024 sample_valid_i, clear_i ignored outside IDLE; no backpressure on tap stream (MAC always accepts).

Reset
REQ-025 rst_ni low SHALL asynchronously force state=CLEAR, clr_cnt=0, wr_ptr=0, k=0, tap pipeline registers 0.
REQ-026 During reset all outputs 0: sample_ready_o, ena_o, wea_o, enb_o, tap_valid_o, tap_last_o, addr/data outputs 0; busy_o=1 once reset releases (CLEAR running).
REQ-027 Reset mid-READ SHALL abort the stream with no further tap_valid_o and re-clear the delay line.

Verification (AddrWidth=4, NumTaps=4, DPRAM model attached)
REQ-028 Release reset -> 16 zero writes addra 0..15, busy_o=1 for 16 cycles, then sample_ready_o=1.
REQ-029 Feed samples 0x0001,0x0002,0x0003 -> third sample yields taps 0x0003,0x0002,0x0001,0x0000, tap_last_o on idx 3 only.
REQ-030 Feed 20 samples 1..20 -> wr_ptr wraps; 20th sample yields taps 20,19,18,17 with addrb_o 3,2,1,0.
REQ-031 Hold sample_valid_i=1 continuously -> one acceptance every NumTaps+3=7 cycles, no sample lost or duplicated.
REQ-032 clear_i and sample_valid_i both high in IDLE -> no acceptance, 16-cycle CLEAR, next sample's taps 2..3 read 0.
REQ-033 Assert rst_ni low during READ at k=2 -> tap_valid_o drops immediately, CLEAR restarts at address 0.
